// File: rtl/secuenciador_desplazamiento.sv
// Operand sequencer and result register wrapped around the 8-bit combinational left shifter.
// Optional feature: define CONTADOR_OPS_EN to add the ops_completadas output-transfer counter.
module secuenciador_desplazamiento #(
  parameter int ANCHO_DATO = 8,
  parameter int ANCHO_CANT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ANCHO_DATO-1:0] dato_in,
  input  logic                  dato_valido,
  output logic                  dato_listo,
  output logic [ANCHO_DATO-1:0] Desplazar,
  output logic [ANCHO_CANT-1:0] Cantidad,
  input  logic [ANCHO_DATO-1:0] Desplazados,
  output logic [ANCHO_DATO-1:0] resultado,
  output logic                  cero,
  output logic                  desbordado,
  output logic                  resultado_valido,
  input  logic                  resultado_listo
`ifdef CONTADOR_OPS_EN
  ,
  output logic [7:0]            ops_completadas
`endif
);

  typedef enum logic [1:0] {
    ESPERA_A,
    ESPERA_B,
    EJECUTAR,
    ENTREGAR
  } estado_t;

  estado_t estado;

  logic acepta_dato;
  logic entrega_resultado;

  assign acepta_dato       = dato_valido && dato_listo;
  assign entrega_resultado = resultado_valido && resultado_listo;

  // dato_listo is registered, so it is set for the state being entered, not the current one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado           <= ESPERA_A;
      dato_listo       <= 1'b0;
      Desplazar        <= '0;
      Cantidad         <= '0;
      resultado        <= '0;
      cero             <= 1'b0;
      desbordado       <= 1'b0;
      resultado_valido <= 1'b0;
    end else begin
      case (estado)
        ESPERA_A: begin
          dato_listo <= 1'b1;
          if (acepta_dato) begin
            Desplazar <= dato_in;
            estado    <= ESPERA_B;
          end
        end
        ESPERA_B: begin
          dato_listo <= 1'b1;
          if (acepta_dato) begin
            Cantidad   <= dato_in[ANCHO_CANT-1:0];
            dato_listo <= 1'b0;
            estado     <= EJECUTAR;
          end
        end
        EJECUTAR: begin
          resultado        <= Desplazados;
          cero             <= (Desplazados == '0);
          // Shifting back recovers the operand only when nothing nonzero fell off the top.
          desbordado       <= ((Desplazados >> Cantidad) != Desplazar);
          resultado_valido <= 1'b1;
          dato_listo       <= 1'b0;
          estado           <= ENTREGAR;
        end
        ENTREGAR: begin
          if (entrega_resultado) begin
            resultado_valido <= 1'b0;
            dato_listo       <= 1'b1;
            estado           <= ESPERA_A;
          end
        end
        default: begin
          dato_listo <= 1'b0;
          estado     <= ESPERA_A;
        end
      endcase
    end
  end

`ifdef CONTADOR_OPS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ops_completadas <= 8'd0;
    end else if (entrega_resultado) begin
      ops_completadas <= ops_completadas + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_secuenciador_desplazamiento.sv
// Self-checking bench for secuenciador_desplazamiento against an arithmetic shift model.
// Build with CONTADOR_OPS_EN defined to also exercise the ops_completadas counter.
module tb_secuenciador_desplazamiento;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] dato_in = 8'd0;
  logic       dato_valido = 1'b0;
  logic       dato_listo;
  logic [7:0] Desplazar;
  logic [2:0] Cantidad;
  logic [7:0] Desplazados;
  logic [7:0] resultado;
  logic       cero;
  logic       desbordado;
  logic       resultado_valido;
  logic       resultado_listo = 1'b0;
`ifdef CONTADOR_OPS_EN
  logic [7:0] ops_completadas;
`endif

  int tests_run = 0;
  int fails     = 0;
  int ops_done  = 0;

  always #5 clk = ~clk;

  // Stand-in for the external combinational left shifter.
  assign Desplazados = Desplazar << Cantidad;

  secuenciador_desplazamiento dut (
    .clk              (clk),
    .rst              (rst),
    .dato_in          (dato_in),
    .dato_valido      (dato_valido),
    .dato_listo       (dato_listo),
    .Desplazar        (Desplazar),
    .Cantidad         (Cantidad),
    .Desplazados      (Desplazados),
    .resultado        (resultado),
    .cero             (cero),
    .desbordado       (desbordado),
    .resultado_valido (resultado_valido),
    .resultado_listo  (resultado_listo)
`ifdef CONTADOR_OPS_EN
    ,
    .ops_completadas  (ops_completadas)
`endif
  );

  // Reference: multiply by 2**amount; low byte is the result, anything above is overflow.
  function automatic logic [8:0] ref_shift(input logic [7:0] a, input logic [7:0] b);
    int amt;
    int full;
    logic [7:0] res;
    logic ovf;
    amt  = int'(b) % 8;
    full = int'(a) * (1 << amt);
    res  = 8'(full % 256);
    ovf  = (full / 256) != 0;
    return {ovf, res};
  endfunction

  // Tasks start and end just after a falling edge; the rising edge in between does the transfer.
  task automatic send_byte(input logic [7:0] v);
    int waited;
    waited = 0;
    dato_in = v;
    dato_valido = 1'b1;
    while (dato_listo !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (dato_listo !== 1'b1) begin
      tests_run++;
      fails++;
      $display("[TB] FAIL send_byte_timeout: dato_listo=%b required 1", dato_listo);
    end
    @(negedge clk);
    dato_valido = 1'b0;
    dato_in = 8'($urandom);
  endtask

  task automatic send_operands(input logic [7:0] a, input logic [7:0] b);
    send_byte(a);
    send_byte(b);
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests_run++;
    if ({dato_listo, Desplazar, Cantidad, resultado, cero, desbordado, resultado_valido} !== 22'd0) begin
      fails++;
      $display("[TB] FAIL reset_values: got listo=%b a=%h c=%h r=%h z=%b o=%b v=%b required all 0",
               dato_listo, Desplazar, Cantidad, resultado, cero, desbordado, resultado_valido);
    end
`ifdef CONTADOR_OPS_EN
    tests_run++;
    if (ops_completadas !== 8'd0) begin
      fails++;
      $display("[TB] FAIL reset_counter: got %0d required 0", ops_completadas);
    end
`endif
    rst = 1'b0;
    ops_done = 0;
    @(negedge clk);
    tests_run++;
    if (dato_listo !== 1'b1) begin
      fails++;
      $display("[TB] FAIL reset_release_listo: got %b required 1", dato_listo);
    end
  endtask

  task automatic test_spec_vectors();
    logic [7:0] va [4] = '{8'h81, 8'h0F, 8'h80, 8'h5A};
    logic [7:0] vb [4] = '{8'h01, 8'hFB, 8'h01, 8'h00};
    logic [8:0] exp;
    resultado_listo = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp = ref_shift(va[i], vb[i]);
      send_operands(va[i], vb[i]);
      tests_run++;
      if ({resultado_valido, dato_listo, Desplazar, Cantidad} !== {1'b0, 1'b0, va[i], 3'(vb[i] & 8'h07)}) begin
        fails++;
        $display("[TB] FAIL vec%0d_execute: got v=%b listo=%b a=%h c=%0d required v=0 listo=0 a=%h c=%0d",
                 i, resultado_valido, dato_listo, Desplazar, Cantidad, va[i], vb[i] & 8'h07);
      end
      @(negedge clk);
      tests_run++;
      if ({resultado_valido, resultado, cero, desbordado} !== {1'b1, exp[7:0], exp[7:0] == 8'd0, exp[8]}) begin
        fails++;
        $display("[TB] FAIL vec%0d_result: got v=%b r=%h z=%b o=%b required v=1 r=%h z=%b o=%b",
                 i, resultado_valido, resultado, cero, desbordado, exp[7:0], exp[7:0] == 8'd0, exp[8]);
      end
      @(negedge clk);
      ops_done++;
      tests_run++;
      if ({resultado_valido, dato_listo} !== 2'b01) begin
        fails++;
        $display("[TB] FAIL vec%0d_one_cycle: got v=%b listo=%b required v=0 listo=1",
                 i, resultado_valido, dato_listo);
      end
    end
  endtask

  task automatic test_idle_wait();
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] prev_a;
    logic [2:0] prev_c;
    logic [8:0] exp;
    a = 8'($urandom);
    b = 8'($urandom);
    exp = ref_shift(a, b);
    prev_a = Desplazar;
    prev_c = Cantidad;
    resultado_listo = 1'b1;
    repeat (5) @(negedge clk);
    tests_run++;
    if ({dato_listo, Desplazar, Cantidad} !== {1'b1, prev_a, prev_c}) begin
      fails++;
      $display("[TB] FAIL idle_espera_a: got listo=%b a=%h c=%0d required listo=1 a=%h c=%0d",
               dato_listo, Desplazar, Cantidad, prev_a, prev_c);
    end
    send_byte(a);
    repeat (5) @(negedge clk);
    tests_run++;
    if ({dato_listo, Desplazar, Cantidad, resultado_valido} !== {1'b1, a, prev_c, 1'b0}) begin
      fails++;
      $display("[TB] FAIL idle_espera_b: got listo=%b a=%h c=%0d v=%b required listo=1 a=%h c=%0d v=0",
               dato_listo, Desplazar, Cantidad, resultado_valido, a, prev_c);
    end
    send_byte(b);
    @(negedge clk);
    tests_run++;
    if ({resultado_valido, resultado, desbordado} !== {1'b1, exp[7:0], exp[8]}) begin
      fails++;
      $display("[TB] FAIL idle_result: got v=%b r=%h o=%b required v=1 r=%h o=%b",
               resultado_valido, resultado, desbordado, exp[7:0], exp[8]);
    end
    @(negedge clk);
    ops_done++;
  endtask

  task automatic test_stall();
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] exp;
    logic [22:0] frozen;
    a = 8'($urandom_range(1, 255));
    b = 8'($urandom);
    exp = ref_shift(a, b);
    resultado_listo = 1'b0;
    send_operands(a, b);
    @(negedge clk);
    frozen = {1'b1, 1'b0, exp[7:0], exp[7:0] == 8'd0, exp[8], a, 3'(b & 8'h07)};
    for (int i = 0; i < 10; i++) begin
      tests_run++;
      if ({resultado_valido, dato_listo, resultado, cero, desbordado, Desplazar, Cantidad} !== frozen) begin
        fails++;
        $display("[TB] FAIL stall_cycle%0d: got v=%b listo=%b r=%h z=%b o=%b a=%h c=%0d required %h",
                 i, resultado_valido, dato_listo, resultado, cero, desbordado, Desplazar, Cantidad, frozen);
      end
      @(negedge clk);
    end
    resultado_listo = 1'b1;
    @(negedge clk);
    ops_done++;
    tests_run++;
    if ({resultado_valido, dato_listo} !== 2'b01) begin
      fails++;
      $display("[TB] FAIL stall_release: got v=%b listo=%b required v=0 listo=1", resultado_valido, dato_listo);
    end
`ifdef CONTADOR_OPS_EN
    tests_run++;
    if (ops_completadas !== 8'(ops_done)) begin
      fails++;
      $display("[TB] FAIL stall_counter: got %0d required %0d", ops_completadas, ops_done % 256);
    end
`endif
  endtask

  task automatic test_reset_mid();
    logic [8:0] exp;
    resultado_listo = 1'b1;
    send_byte(8'hC3);
    #2 rst = 1'b1;
    #1;
    ops_done = 0;
    tests_run++;
    if ({dato_listo, Desplazar, Cantidad, resultado, cero, desbordado, resultado_valido} !== 22'd0) begin
      fails++;
      $display("[TB] FAIL reset_mid_operand: got listo=%b a=%h c=%0d r=%h v=%b required all 0",
               dato_listo, Desplazar, Cantidad, resultado, resultado_valido);
    end
    @(negedge clk);
    rst = 1'b0;
    // Two fresh operands: the discarded 0xC3 must not reappear as the value.
    exp = ref_shift(8'h15, 8'h02);
    send_operands(8'h15, 8'h02);
    @(negedge clk);
    tests_run++;
    if ({resultado_valido, resultado, desbordado, Desplazar} !== {1'b1, exp[7:0], exp[8], 8'h15}) begin
      fails++;
      $display("[TB] FAIL reset_mid_recover: got v=%b r=%h o=%b a=%h required v=1 r=%h o=%b a=15",
               resultado_valido, resultado, desbordado, Desplazar, exp[7:0], exp[8]);
    end
    @(negedge clk);
    ops_done++;
    resultado_listo = 1'b0;
    send_operands(8'h01, 8'h07);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    ops_done = 0;
    tests_run++;
    if ({resultado_valido, resultado, Desplazar, Cantidad, dato_listo} !== 21'd0) begin
      fails++;
      $display("[TB] FAIL reset_mid_delivery: got v=%b r=%h a=%h c=%0d listo=%b required all 0",
               resultado_valido, resultado, Desplazar, Cantidad, dato_listo);
    end
    @(negedge clk);
    rst = 1'b0;
    resultado_listo = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] exp;
    int stall;
    for (int n = 0; n < 40; n++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      exp = ref_shift(a, b);
      stall = int'($urandom_range(0, 4));
      resultado_listo = (stall == 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send_operands(a, b);
      @(negedge clk);
      tests_run++;
      if ({resultado_valido, resultado, cero, desbordado, Cantidad} !==
          {1'b1, exp[7:0], exp[7:0] == 8'd0, exp[8], 3'(b & 8'h07)}) begin
        fails++;
        $display("[TB] FAIL random%0d a=%h b=%h: got v=%b r=%h z=%b o=%b c=%0d required v=1 r=%h z=%b o=%b",
                 n, a, b, resultado_valido, resultado, cero, desbordado, Cantidad,
                 exp[7:0], exp[7:0] == 8'd0, exp[8]);
      end
      repeat (stall) @(negedge clk);
      resultado_listo = 1'b1;
      @(negedge clk);
      ops_done++;
      tests_run++;
      if ({resultado_valido, dato_listo} !== 2'b01) begin
        fails++;
        $display("[TB] FAIL random%0d_handoff: got v=%b listo=%b required v=0 listo=1",
                 n, resultado_valido, dato_listo);
      end
    end
  endtask

  task automatic test_back_to_back();
    int count;
    logic [8:0] exp;
    logic [7:0] a;
    logic [7:0] b;
    int bad;
`ifdef CONTADOR_OPS_EN
    count = 257;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ops_done = 0;
`else
    count = 20;
`endif
    bad = 0;
    resultado_listo = 1'b1;
    for (int n = 0; n < count; n++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      exp = ref_shift(a, b);
      send_operands(a, b);
      @(negedge clk);
      if (resultado !== exp[7:0] || desbordado !== exp[8] || resultado_valido !== 1'b1) begin
        bad++;
      end
      @(negedge clk);
      ops_done++;
    end
    tests_run++;
    if (bad != 0) begin
      fails++;
      $display("[TB] FAIL back_to_back_results: got %0d wrong results required 0", bad);
    end
`ifdef CONTADOR_OPS_EN
    tests_run++;
    if (ops_completadas !== 8'(ops_done)) begin
      fails++;
      $display("[TB] FAIL counter_wrap: got %0d required %0d", ops_completadas, ops_done % 256);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_spec_vectors();
    test_idle_wait();
    test_stall();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
